count_arbiter: RTL and testbench

Round-robin scheduler that shares one 4-bit up counter between NREQ requesters. Each requester asks for a timed run of a given length. The arbiter grants one requester at a time, clears the counter, enables it until it reaches the requested terminal value, then pulses done and releases the counter. It sits between client control logic and the shared counting datapath.

---
 rtl/count_arb_pkg.sv | 39 +++
 rtl/tick_counter.sv | 18 +
 rtl/count_arbiter.sv | 114 +++++++++++
 tb/tb_count_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/count_arb_pkg.sv
// Shared types and the round-robin pick helper for count_arbiter.
// The pick works on a fixed-size request vector so any NREQ up to MAX_NREQ can use it.
package count_arb_pkg;

    localparam int DEF_NREQ  = 2;
    localparam int DEF_WIDTH = 4;
    localparam int MAX_NREQ  = 8;
    localparam int MAX_IDXW  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_IDXW-1:0] idx;
    } pick_t;

    // The search starts one past the last winner and wraps modulo n.
    // The first requester found in that order wins.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                      input logic [MAX_IDXW-1:0] last,
                                      input int                  n);
        pick_t p;
        int    pos;
        p = '0;
        for (int k = 1; k <= MAX_NREQ; k++) begin
            pos = (int'(last) + k) % n;
            if (k <= n && !p.valid && req[pos]) begin
                p.valid = 1'b1;
                p.idx   = MAX_IDXW'(pos);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Shared WIDTH-bit up counter; the arbiter owns its reset and enable.
module tick_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (enable)
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/count_arbiter.sv
// Round-robin owner of one shared tick_counter: grant, clear, count to the
// requested length, pulse done, release.
//
// Handshake: a requester raises req and holds it until it sees done with its
// index on done_id; dropping req while granted aborts the run with no done.
module count_arbiter
    import count_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   len,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [WIDTH-1:0]        count,
    output state_t                  dbg_state
);

    localparam int IDXW = $clog2(NREQ);

    state_t              state;
    logic [IDXW-1:0]     last_q;
    logic [WIDTH-1:0]    len_q;

    logic [MAX_NREQ-1:0] req_ext;
    logic [MAX_IDXW-1:0] last_ext;
    pick_t               pick;
    logic [IDXW-1:0]     win;
    logic [NREQ-1:0]     win_onehot;
    logic                held;
    logic                at_end;
    logic                cnt_reset;
    logic                cnt_enable;

    always_comb begin
        req_ext              = '0;
        req_ext[NREQ-1:0]    = req;
        last_ext             = '0;
        last_ext[IDXW-1:0]   = last_q;
        pick                 = rr_pick(req_ext, last_ext, NREQ);
        win                  = IDXW'(pick.idx);
        win_onehot           = '0;
        win_onehot[win]      = 1'b1;
        // last_q doubles as the current winner while RUN/DONE
        held                 = req[last_q];
        at_end               = (count == len_q);
        cnt_enable           = (state == RUN) && held && !at_end;
        cnt_reset            = reset || (state != RUN) || !held;
    end

    tick_counter #(
        .WIDTH (WIDTH)
    ) u_tick_counter (
        .clk    (clk),
        .reset  (cnt_reset),
        .enable (cnt_enable),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            len_q   <= '0;
            last_q  <= IDXW'(NREQ - 1);
        end else begin
            done    <= 1'b0;
            done_id <= '0;
            case (state)
                IDLE: begin
                    if (pick.valid) begin
                        state  <= RUN;
                        gnt    <= win_onehot;
                        busy   <= 1'b1;
                        len_q  <= len[win*WIDTH +: WIDTH];
                        last_q <= win;
                    end
                end
                RUN: begin
                    if (!held) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else if (at_end) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        done_id <= last_q;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter (NREQ=2, WIDTH=4): single run, fairness,
// zero length, full range, abort and reset mid-run.
module tb_count_arbiter;
    import count_arb_pkg::*;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [7:0] len;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic [0:0] done_id;
    logic [3:0] count;
    state_t     dbg_state;

    int n_cmp;
    int n_bad;
    logic [1:0] exp_q[$];
    logic [1:0] exp_g;

    count_arbiter #(.NREQ(2), .WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .len       (len),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .count     (count),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        req   = 2'b00;
        len   = 8'h00;
        @(negedge clk);
        do_reset();

        // reset state
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // single request, len0 = 3
        req = 2'b01;
        len = 8'h03;
        step();
        check("single_gnt", 32'(gnt), 32'h1);
        check("single_busy", 32'(busy), 32'h1);
        check("single_cnt0", 32'(count), 32'h0);
        check("single_state", 32'(dbg_state), 32'(RUN));
        for (int n = 1; n <= 3; n++) begin
            step();
            check("single_cnt", 32'(count), 32'(n));
            check("single_nodone", 32'(done), 32'h0);
        end
        step();
        check("single_done", 32'(done), 32'h1);
        check("single_done_id", 32'(done_id), 32'h0);
        check("single_done_cnt", 32'(count), 32'h3);
        check("single_done_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        step();
        check("single_idle_gnt", 32'(gnt), 32'h0);
        check("single_idle_cnt", 32'(count), 32'h0);
        check("single_idle_busy", 32'(busy), 32'h0);
        check("single_idle_done", 32'(done), 32'h0);

        // fairness from reset: both held, len = 1 each
        do_reset();
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        req = 2'b11;
        len = 8'h11;
        while (exp_q.size() > 0) begin
            exp_g = exp_q.pop_front();
            step();
            check("fair_gnt", 32'(gnt), 32'(exp_g));
            step();
            check("fair_cnt1", 32'(count), 32'h1);
            step();
            check("fair_done", 32'(done), 32'h1);
            check("fair_done_id", 32'(done_id), (exp_g == 2'b10) ? 32'h1 : 32'h0);
            step();
            check("fair_idle_gnt", 32'(gnt), 32'h0);
        end
        req = 2'b00;

        // zero length on requester 1
        req = 2'b10;
        len = 8'h00;
        step();
        check("zero_gnt", 32'(gnt), 32'h2);
        check("zero_busy1", 32'(busy), 32'h1);
        check("zero_cnt", 32'(count), 32'h0);
        step();
        check("zero_done", 32'(done), 32'h1);
        check("zero_done_id", 32'(done_id), 32'h1);
        check("zero_busy2", 32'(busy), 32'h1);
        req = 2'b00;
        step();
        check("zero_busy_off", 32'(busy), 32'h0);
        check("zero_no_done", 32'(done), 32'h0);

        // full range on requester 0
        req = 2'b01;
        len = 8'h0F;
        step();
        check("full_gnt", 32'(gnt), 32'h1);
        for (int n = 1; n <= 15; n++) begin
            step();
            check("full_cnt", 32'(count), 32'(n));
            check("full_nodone", 32'(done), 32'h0);
        end
        step();
        check("full_done", 32'(done), 32'h1);
        check("full_done_cnt", 32'(count), 32'hF);
        req = 2'b00;
        step();
        check("full_idle_cnt", 32'(count), 32'h0);
        check("full_idle_gnt", 32'(gnt), 32'h0);

        // abort of requester 0 at count 4, requester 1 pending
        req = 2'b01;
        len = 8'h2A;
        step();
        check("abort_gnt", 32'(gnt), 32'h1);
        step();
        step();
        req = 2'b11;
        step();
        step();
        check("abort_cnt4", 32'(count), 32'h4);
        req = 2'b10;
        step();
        check("abort_gnt_off", 32'(gnt), 32'h0);
        check("abort_cnt", 32'(count), 32'h0);
        check("abort_no_done", 32'(done), 32'h0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        step();
        check("abort_next_gnt", 32'(gnt), 32'h2);
        step();
        step();
        check("abort_r1_cnt2", 32'(count), 32'h2);
        step();
        check("abort_r1_done", 32'(done), 32'h1);
        check("abort_r1_id", 32'(done_id), 32'h1);
        req = 2'b00;
        step();

        // reset in the middle of a run
        req = 2'b01;
        len = 8'h0A;
        step();
        for (int n = 1; n <= 6; n++) step();
        check("mid_cnt6", 32'(count), 32'h6);
        reset = 1'b1;
        step();
        check("mid_gnt", 32'(gnt), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_done", 32'(done), 32'h0);
        check("mid_cnt", 32'(count), 32'h0);
        reset = 1'b0;
        req   = 2'b11;
        step();
        check("mid_first_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        step();

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
